// File: rtl/div_seq_n.sv
// div_seq_n: sequential restoring divider, one quotient bit per clock.
// Optional `DIV_SEQ_N_DBZ_FAST_EN: zero divisor completes in one cycle.
module div_seq_n #(
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [n-1:0] dividend,
    input  logic [n-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [n-1:0] quotient,
    output logic [n-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = $clog2(n + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [n-1:0]  r_q, r_d;
    logic [n-1:0]  q_q, q_d;
    logic [n-1:0]  d_q, d_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [n-1:0]  quo_q, quo_d;
    logic [n-1:0]  rem_q, rem_d;
    logic          dbz_q, dbz_d;
    logic [n:0]    sh;
    logic [n:0]    t;

    always_comb begin
        // R stays below D after each restore, so n bits hold it
        sh      = {r_q, q_q[n-1]};
        t       = sh - {1'b0, d_q};
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    q_d     = dividend;
                    d_d     = divisor;
                    r_d     = '0;
                    cnt_d   = CW'(n);
                    state_d = RUN;
`ifdef DIV_SEQ_N_DBZ_FAST_EN
                    if (divisor == '0) begin
                        state_d = DONE;
                        cnt_d   = '0;
                        quo_d   = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                    end
`endif
                end
            end
            RUN: begin
                r_d   = t[n] ? sh[n-1:0] : t[n-1:0];
                q_d   = {q_q[n-2:0], ~t[n]};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    quo_d   = q_d;
                    rem_d   = r_d;
                    dbz_d   = (d_q == '0);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_seq_n.sv
// tb_div_seq_n: directed n=8 scenarios plus n=32 random regression,
// scoreboard of expected results popped on each done pulse.
module tb_div_seq_n;

`ifdef DIV_SEQ_N_DBZ_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;

    logic        s8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8, z8;
    logic [7:0]  q8, r8;

    logic        s32 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0;
    logic        busy32, done32, z32;
    logic [31:0] q32, r32;

    div_seq_n #(.n(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(s8),
        .dividend(a8), .divisor(b8),
        .busy(busy8), .done(done8),
        .quotient(q8), .remainder(r8), .div_by_zero(z8)
    );

    div_seq_n #(.n(32)) u32 (
        .clk(clk), .rst_n(rst_n), .start(s32),
        .dividend(a32), .divisor(b32),
        .busy(busy32), .done(done32),
        .quotient(q32), .remainder(r32), .div_by_zero(z32)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
        int          due;
    } exp_t;

    exp_t sb8[$];
    exp_t sb32[$];
    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic pd8 = 1'b0;
    always @(negedge clk) begin
        if (done8) begin
            chk("done8_pulse", pd8, 0);
            chk("done8_busy", busy8, 0);
            chk("done8_expected", sb8.size() != 0, 1);
            if (sb8.size() != 0) begin
                exp_t e;
                e = sb8.pop_front();
                chk("q8", q8, e.q);
                chk("r8", r8, e.r);
                chk("z8", z8, e.z);
                chk("lat8", cyc, e.due);
            end
        end
        pd8 <= done8;
    end

    logic pd32 = 1'b0;
    always @(negedge clk) begin
        if (done32) begin
            chk("done32_pulse", pd32, 0);
            chk("done32_expected", sb32.size() != 0, 1);
            if (sb32.size() != 0) begin
                exp_t e;
                e = sb32.pop_front();
                chk("q32", q32, e.q);
                chk("r32", r32, e.r);
                chk("z32", z32, e.z);
                chk("lat32", cyc, e.due);
            end
        end
        pd32 <= done32;
    end

    task automatic issue8(input logic [7:0] a, input logic [7:0] b,
                          input bit keep);
        exp_t e;
        bool_fast: begin end
        e.q   = (b == 0) ? 32'hFF : 32'(a / b);
        e.r   = (b == 0) ? 32'(a) : 32'(a % b);
        e.z   = (b == 0);
        e.due = cyc + 1 + ((FAST && b == 0) ? 0 : 8);
        s8 = 1'b1;
        a8 = a;
        b8 = b;
        sb8.push_back(e);
        @(posedge clk);
        #1;
        if (!keep) s8 = 1'b0;
        chk("busy8_after_start", busy8, !(FAST && b == 0));
    endtask

    task automatic issue32(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.q   = a / b;
        e.r   = a % b;
        e.z   = 1'b0;
        e.due = cyc + 1 + 32;
        s32 = 1'b1;
        a32 = a;
        b32 = b;
        sb32.push_back(e);
        @(posedge clk);
        #1;
        s32 = 1'b0;
    endtask

    task automatic wait8();
        int i = 0;
        while (sb8.size() != 0 && i < 100) begin
            @(negedge clk);
            i++;
        end
        chk("drain8", sb8.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait32();
        int i = 0;
        while (sb32.size() != 0 && i < 100) begin
            @(negedge clk);
            i++;
        end
        chk("drain32", sb32.size(), 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, busy8, 0);
        chk({tag, "_done"}, done8, 0);
        chk({tag, "_q"}, q8, 0);
        chk({tag, "_r"}, r8, 0);
        chk({tag, "_z"}, z8, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] a, b;
        int w;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk_zero("post_reset");

        issue8(8'd100, 8'd7, 1'b0);
        wait8();

        issue8(8'd255, 8'd1, 1'b1);
        a8 = 8'd5;
        b8 = 8'd9;
        w = 0;
        while (!done8 && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("b2b_first_done", done8, 1);
        issue8(8'd5, 8'd9, 1'b0);
        wait8();

        issue8(8'd37, 8'd0, 1'b0);
        if (FAST) chk("dbz_fast_busy", busy8, 0);
        wait8();

        issue8(8'd200, 8'd3, 1'b0);
        repeat (3) @(negedge clk);
        s8 = 1'b1;
        a8 = 8'd9;
        b8 = 8'd9;
        @(negedge clk);
        s8 = 1'b0;
        wait8();

        s8 = 1'b1;
        a8 = 8'd77;
        b8 = 8'd5;
        @(posedge clk);
        #1;
        s8 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_zero("mid_reset");
        repeat (2) @(negedge clk);
        chk_zero("mid_reset_hold");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("no_stale_done", done8, 0);
        issue8(8'd50, 8'd6, 1'b0);
        wait8();

        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            unique case (i % 4)
                0: b = a;
                1: b = $urandom;
                2: b = 32'($urandom_range(1, 255));
                default: begin
                    a = a >> 1;
                    b = a | 32'h8000_0000;
                end
            endcase
            if (b == 0) b = 32'd1;
            issue32(a, b);
            wait32();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
